// File: rtl/noc_mem_server.sv
// NoC memory node: serves filter/ifmap read packets, collects result packets, reads results back.
// Optional feature macro RESULT_ACCUM_EN: result writes accumulate (saturating) over ACC_PASSES passes.
module noc_mem_server #(
  parameter int NODE_W     = 4,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int FILTER_NUM = 5,
  parameter int IFMAP_NUM  = 7,
  parameter int DEPTH_R    = 3,
  parameter int WIDTH_R    = 3,
  parameter int ACC_PASSES = 1,
  parameter int PKT_W      = 2 + 2*NODE_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NODE_W-1:0] node_index,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_sel,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              pkt_in_valid,
  output logic              pkt_in_ready,
  input  logic [PKT_W-1:0]  pkt_in_data,
  output logic              pkt_out_valid,
  input  logic              pkt_out_ready,
  output logic [PKT_W-1:0]  pkt_out_data,
  input  logic              rd_req_valid,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              done,
  output logic [7:0]        err_cnt
);

  localparam int FILTER_WORDS = FILTER_NUM * FILTER_NUM;
  localparam int IFMAP_WORDS  = IFMAP_NUM * IFMAP_NUM;
  localparam int RESULT_NUM   = DEPTH_R * WIDTH_R;
  localparam int FI_W         = $clog2(FILTER_WORDS);
  localparam int II_W         = $clog2(IFMAP_WORDS);
  localparam int RI_W         = $clog2(RESULT_NUM);
  localparam int RP_W         = $clog2(RESULT_NUM + 1);
  localparam logic [1:0] T_RES = 2'b00;
  localparam logic [1:0] T_IFM = 2'b01;
  localparam logic [1:0] T_FLT = 2'b10;
  localparam logic [1:0] T_ILL = 2'b11;

  typedef enum logic [1:0] {LOAD = 2'd0, SERVE = 2'd1, DONE = 2'd2} state_t;

  state_t            state_r, state_s;
  logic [DATA_W-1:0] filter_mem [FILTER_WORDS];
  logic [DATA_W-1:0] ifmap_mem  [IFMAP_WORDS];
  logic [DATA_W-1:0] result_mem [RESULT_NUM];
  logic              filter_loaded_r, ifmap_loaded_r;
  logic [RP_W-1:0]   res_ptr_r;
  logic [RI_W-1:0]   res_idx_s;
  logic [1:0]        pkt_type_s;
  logic [NODE_W-1:0] pkt_src_s;
  logic [DATA_W-1:0] pkt_payload_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              in_fire_s, rd_pkt_s, rd_fire_s, rd_in_range_s, res_fire_s, ill_fire_s;
  logic              load_fire_s, load_ok_s, load_err_s, pkt_err_s, last_write_s, clear_s;
  logic [1:0]        err_inc_s;
  logic              unused_fields;

`ifdef RESULT_ACCUM_EN
  localparam int PC_W = $clog2(ACC_PASSES + 1);
  logic [PC_W-1:0] pass_cnt_r;
  logic            ptr_wrap_s;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
  endfunction
`endif

  function automatic logic [7:0] sat_err(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  assign pkt_type_s    = pkt_in_data[PKT_W-1 -: 2];
  assign pkt_src_s     = pkt_in_data[PKT_W-3 -: NODE_W];
  assign pkt_payload_s = pkt_in_data[DATA_W-1:0];
  assign res_idx_s     = res_ptr_r[RI_W-1:0];
  // The destination field is not checked: the NoC delivers only packets addressed to this node.
  assign unused_fields = ^{pkt_in_data[DATA_W +: NODE_W], 1'(ACC_PASSES != 0)};
  assign pkt_in_ready  = (state_r == SERVE) && (!pkt_out_valid || pkt_out_ready);

  // Ingress decode, range checks, error sources and next-state logic.
  always_comb begin
    rd_word_s     = '0;
    rd_in_range_s = 1'b0;
    rd_pkt_s      = 1'b0;
    in_fire_s     = pkt_in_valid && pkt_in_ready;
    case (pkt_type_s)
      T_IFM: begin
        rd_pkt_s      = 1'b1;
        rd_in_range_s = pkt_payload_s < DATA_W'(IFMAP_WORDS);
        if (rd_in_range_s) rd_word_s = ifmap_mem[pkt_payload_s[II_W-1:0]];
        else               rd_word_s = '0;
      end
      T_FLT: begin
        rd_pkt_s      = 1'b1;
        rd_in_range_s = pkt_payload_s < DATA_W'(FILTER_WORDS);
        if (rd_in_range_s) rd_word_s = filter_mem[pkt_payload_s[FI_W-1:0]];
        else               rd_word_s = '0;
      end
      default: begin
        rd_pkt_s = 1'b0;
      end
    endcase
    rd_fire_s   = in_fire_s && rd_pkt_s;
    res_fire_s  = in_fire_s && (pkt_type_s == T_RES);
    ill_fire_s  = in_fire_s && (pkt_type_s == T_ILL);
    load_fire_s = load_valid && load_ready;
    if (load_sel) load_ok_s = load_addr < ADDR_W'(IFMAP_WORDS);
    else          load_ok_s = load_addr < ADDR_W'(FILTER_WORDS);
    load_err_s = load_fire_s && !load_ok_s;
    pkt_err_s  = (rd_fire_s && !rd_in_range_s) || ill_fire_s;
    err_inc_s  = {1'b0, load_err_s} + {1'b0, pkt_err_s};
`ifdef RESULT_ACCUM_EN
    ptr_wrap_s   = res_ptr_r == RP_W'(RESULT_NUM - 1);
    last_write_s = res_fire_s && !start && ptr_wrap_s && (pass_cnt_r == PC_W'(ACC_PASSES - 1));
`else
    last_write_s = res_fire_s && !start && (res_ptr_r == RP_W'(RESULT_NUM - 1));
`endif
    clear_s = start && (state_r != LOAD);
    state_s = state_r;
    case (state_r)
      LOAD:    if (filter_loaded_r && ifmap_loaded_r) state_s = SERVE; else state_s = LOAD;
      SERVE:   if (last_write_s) state_s = DONE; else state_s = SERVE;
      DONE:    if (start) state_s = SERVE; else state_s = DONE;
      default: state_s = LOAD;
    endcase
  end

  // State register, done level, preload handshake, loaded flags and error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= LOAD;
      done            <= 1'b0;
      load_ready      <= 1'b0;
      err_cnt         <= 8'd0;
      filter_loaded_r <= 1'b0;
      ifmap_loaded_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      done       <= (state_s == DONE);
      load_ready <= 1'b1;
      err_cnt    <= sat_err(err_cnt, err_inc_s);
      if (load_fire_s && !load_sel && (load_addr == ADDR_W'(FILTER_WORDS - 1))) filter_loaded_r <= 1'b1;
      if (load_fire_s && load_sel && (load_addr == ADDR_W'(IFMAP_WORDS - 1))) ifmap_loaded_r <= 1'b1;
    end
  end

  // Filter/ifmap storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (load_fire_s && load_ok_s) begin
      if (load_sel) ifmap_mem[load_addr[II_W-1:0]] <= load_data;
      else          filter_mem[load_addr[FI_W-1:0]] <= load_data;
    end
  end

  // Egress response register, held until the NoC takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_out_valid <= 1'b0;
      pkt_out_data  <= '0;
    end else if (rd_fire_s) begin
      pkt_out_valid <= 1'b1;
      pkt_out_data  <= {pkt_type_s, node_index, pkt_src_s, rd_word_s};
    end else if (pkt_out_ready) begin
      pkt_out_valid <= 1'b0;
    end
  end

  // Result collection and readback; start outside LOAD wipes the result buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RESULT_NUM; i++) result_mem[i] <= '0;
      res_ptr_r     <= '0;
`ifdef RESULT_ACCUM_EN
      pass_cnt_r    <= '0;
`endif
      rd_resp_valid <= 1'b0;
      rd_resp_data  <= '0;
    end else begin
      rd_resp_valid <= rd_req_valid;
      if (rd_req_addr < ADDR_W'(RESULT_NUM)) rd_resp_data <= result_mem[rd_req_addr[RI_W-1:0]];
      else                                    rd_resp_data <= '0;
      if (clear_s) begin
        for (int i = 0; i < RESULT_NUM; i++) result_mem[i] <= '0;
        res_ptr_r  <= '0;
`ifdef RESULT_ACCUM_EN
        pass_cnt_r <= '0;
`endif
      end else if (res_fire_s) begin
`ifdef RESULT_ACCUM_EN
        result_mem[res_idx_s] <= sat_add(result_mem[res_idx_s], pkt_payload_s);
        if (ptr_wrap_s) begin
          res_ptr_r  <= '0;
          pass_cnt_r <= pass_cnt_r + PC_W'(1'b1);
        end else begin
          res_ptr_r <= res_ptr_r + RP_W'(1'b1);
        end
`else
        result_mem[res_idx_s] <= pkt_payload_s;
        res_ptr_r             <= res_ptr_r + RP_W'(1'b1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_noc_mem_server.sv
// Self-checking bench for noc_mem_server: behavioural model compared every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_noc_mem_server;

  localparam int RES_N = 9;
`ifdef RESULT_ACCUM_EN
  localparam int PASSES = 2;
  localparam bit ACCUM  = 1'b1;
  localparam logic [7:0] EXP4 = 8'd255;
  localparam logic [7:0] EXP8 = 8'd255;
`else
  localparam int PASSES = 1;
  localparam bit ACCUM  = 1'b0;
  localparam logic [7:0] EXP4 = 8'd5;
  localparam logic [7:0] EXP8 = 8'd9;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, load_valid, load_ready, load_sel;
  logic [3:0]  node_index;
  logic [7:0]  load_addr, load_data, rd_req_addr, rd_resp_data;
  logic        pkt_in_valid, pkt_in_ready, pkt_out_valid, pkt_out_ready;
  logic [17:0] pkt_in_data, pkt_out_data;
  logic        rd_req_valid, rd_resp_valid, done;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  noc_mem_server #(.ACC_PASSES(2)) dut (
    .clk(clk), .rst_n(rst_n), .node_index(node_index), .start(start),
    .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data),
    .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready), .pkt_in_data(pkt_in_data),
    .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready), .pkt_out_data(pkt_out_data),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  f_mem [0:255];
  logic [7:0]  i_mem [0:255];
  logic [7:0]  r_mem [0:255];
  int          m_phase = 0;  // 0 loading, 1 serving, 2 finished
  bit          m_fl, m_il, m_init = 1'b0;
  int          m_ptr, m_pass, e_err;
  logic        e_load_ready, e_out_valid, e_rd_valid, e_done;
  logic [17:0] e_out_data;
  logic [7:0]  e_rd_data;

  function automatic int bump(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  always @(posedge clk) begin : model
    logic       acc_v;
    logic [1:0] ty_v;
    logic [7:0] pl_v, w_v;
    bit         both_v;
    int         sum_v;
    if (!rst_n) begin
      m_init = 1'b1; m_phase = 0; m_fl = 1'b0; m_il = 1'b0; m_ptr = 0; m_pass = 0;
      for (int k = 0; k < 256; k++) r_mem[k] = 8'd0;
      e_load_ready = 1'b0; e_out_valid = 1'b0; e_out_data = 18'd0;
      e_rd_valid = 1'b0; e_rd_data = 8'd0; e_done = 1'b0; e_err = 0;
    end else begin
      acc_v  = pkt_in_valid && (m_phase == 1) && (!e_out_valid || pkt_out_ready);
      ty_v   = pkt_in_data[17:16];
      pl_v   = pkt_in_data[7:0];
      both_v = m_fl && m_il;
      e_rd_valid = rd_req_valid;
      if (rd_req_valid) e_rd_data = (rd_req_addr < RES_N) ? r_mem[rd_req_addr] : 8'd0;
      if (acc_v && (ty_v == 2'b01 || ty_v == 2'b10)) begin
        if (ty_v == 2'b01 && pl_v < 49) w_v = i_mem[pl_v];
        else if (ty_v == 2'b10 && pl_v < 25) w_v = f_mem[pl_v];
        else begin w_v = 8'd0; e_err = bump(e_err); end
        e_out_valid = 1'b1;
        e_out_data  = {ty_v, node_index, pkt_in_data[15:12], w_v};
      end else if (pkt_out_ready) begin
        e_out_valid = 1'b0;
      end
      if (acc_v && ty_v == 2'b11) e_err = bump(e_err);
      if (start && m_phase != 0) begin
        for (int k = 0; k < 256; k++) r_mem[k] = 8'd0;
        m_ptr = 0; m_pass = 0; m_phase = 1;
      end else if (acc_v && ty_v == 2'b00) begin
        sum_v = r_mem[m_ptr] + pl_v;
        r_mem[m_ptr] = ACCUM ? ((sum_v > 255) ? 8'd255 : 8'(sum_v)) : pl_v;
        m_ptr++;
        if (m_ptr == RES_N) begin
          if (ACCUM) begin
            m_ptr = 0; m_pass++;
            if (m_pass == PASSES) m_phase = 2;
          end else begin
            m_phase = 2;
          end
        end
      end else if (m_phase == 0 && both_v) begin
        m_phase = 1;
      end
      if (load_valid && e_load_ready) begin
        if (!load_sel && load_addr < 25) begin
          f_mem[load_addr] = load_data;
          if (load_addr == 24) m_fl = 1'b1;
        end else if (load_sel && load_addr < 49) begin
          i_mem[load_addr] = load_data;
          if (load_addr == 48) m_il = 1'b1;
        end else begin
          e_err = bump(e_err);
        end
      end
      e_load_ready = 1'b1;
      e_done = (m_phase == 2);
    end
  end

  // Compare all outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (m_init) begin
      check("load_ready", load_ready, e_load_ready);
      check("pkt_in_ready", pkt_in_ready, (m_phase == 1) && (!e_out_valid || pkt_out_ready));
      check("pkt_out_valid", pkt_out_valid, e_out_valid);
      check("pkt_out_data", pkt_out_data, e_out_data);
      check("done", done, e_done);
      check("err_cnt", err_cnt, e_err);
      check("rd_resp_valid", rd_resp_valid, e_rd_valid);
      if (e_rd_valid) check("rd_resp_data", rd_resp_data, e_rd_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input logic [7:0] a, input logic [7:0] d);
    load_valid = 1'b1; load_sel = sel; load_addr = a; load_data = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] ty, input logic [3:0] src, input logic [7:0] pl);
    pkt_in_valid = 1'b1; pkt_in_data = {ty, src, 4'd0, pl};
    tick();
    pkt_in_valid = 1'b0;
  endtask

  task automatic readback(input logic [7:0] a);
    rd_req_valid = 1'b1; rd_req_addr = a;
    tick();
    rd_req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; node_index = 4'd5;
    load_valid = 1'b0; load_sel = 1'b0; load_addr = 8'd0; load_data = 8'd0;
    pkt_in_valid = 1'b0; pkt_in_data = 18'd0; pkt_out_ready = 1'b0;
    rd_req_valid = 1'b0; rd_req_addr = 8'd0;
    repeat (3) tick();
    check("rst_load_ready", load_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err_cnt, 8'd0);
    check("rst_out_valid", pkt_out_valid, 1'b0);
    rst_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("load_ready_up", load_ready, 1'b1);

    for (int i = 0; i < 25; i++) load(1'b0, 8'(i), 8'(i));
    for (int i = 0; i < 48; i++) load(1'b1, 8'(i), 8'(100 + i));
    check("still_load", pkt_in_ready, 1'b0);
    load(1'b1, 8'd48, 8'd148);
    check("flag_then_load", pkt_in_ready, 1'b0);
    tick();
    check("serve_ready", pkt_in_ready, 1'b1);

    send(2'b01, 4'd3, 8'd10);
    check("ifm_resp_valid", pkt_out_valid, 1'b1);
    check("ifm_resp_data", pkt_out_data, {2'b01, 4'd5, 4'd3, 8'd110});
    check("backpressure_ready", pkt_in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_data", pkt_out_data, {2'b01, 4'd5, 4'd3, 8'd110});
      check("hold_valid", pkt_out_valid, 1'b1);
    end
    pkt_out_ready = 1'b1;
    #1;
    check("ready_passthru", pkt_in_ready, 1'b1);
    tick();
    check("resp_taken", pkt_out_valid, 1'b0);

    load_valid = 1'b1; load_sel = 1'b0; load_addr = 8'd2; load_data = 8'd77;
    send(2'b10, 4'd6, 8'd2);
    load_valid = 1'b0;
    check("collide_old", pkt_out_data, {2'b10, 4'd5, 4'd6, 8'd2});
    send(2'b10, 4'd6, 8'd2);
    check("collide_new", pkt_out_data, {2'b10, 4'd5, 4'd6, 8'd77});
    send(2'b10, 4'd7, 8'd24);
    check("flt_last", pkt_out_data, {2'b10, 4'd5, 4'd7, 8'd24});
    send(2'b01, 4'd7, 8'd48);
    check("ifm_last", pkt_out_data, {2'b01, 4'd5, 4'd7, 8'd148});
    send(2'b10, 4'd3, 8'd30);
    check("flt_oob", pkt_out_data, {2'b10, 4'd5, 4'd3, 8'd0});
    send(2'b11, 4'd3, 8'd1);
    check("illegal_noresp", pkt_out_valid, 1'b0);
    check("err_two", err_cnt, 8'd2);
    load(1'b0, 8'd25, 8'd1);
    load(1'b1, 8'd49, 8'd1);
    check("err_load_oob", err_cnt, 8'd4);
    load_valid = 1'b1; load_sel = 1'b1; load_addr = 8'd200;
    send(2'b11, 4'd1, 8'd0);
    load_valid = 1'b0;
    check("err_double", err_cnt, 8'd6);

    for (int k = 0; k < RES_N * PASSES; k++) begin
      send(2'b00, 4'd2, ACCUM ? 8'd200 : 8'(k + 1));
      if (k < RES_N * PASSES - 1) check("done_early", done, 1'b0);
    end
    check("done_set", done, 1'b1);
    check("done_no_ready", pkt_in_ready, 1'b0);
    readback(8'd4);
    check("rb4_valid", rd_resp_valid, 1'b1);
    check("rb4_data", rd_resp_data, EXP4);
    readback(8'd20);
    check("rb20_data", rd_resp_data, 8'd0);
    readback(8'd8);
    check("rb8_data", rd_resp_data, EXP8);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done", done, 1'b0);
    check("restart_ready", pkt_in_ready, 1'b1);
    readback(8'd4);
    check("restart_zero", rd_resp_data, 8'd0);
    send(2'b00, 4'd2, 8'd50);
    send(2'b00, 4'd2, 8'd51);
    readback(8'd0);
    check("serve_wr", rd_resp_data, 8'd50);
    start = 1'b1;
    tick();
    start = 1'b0;
    readback(8'd0);
    check("serve_clear", rd_resp_data, 8'd0);

    pkt_in_valid = 1'b1; pkt_in_data = {2'b11, 4'd1, 4'd0, 8'd0};
    repeat (260) tick();
    pkt_in_valid = 1'b0;
    check("err_sat", err_cnt, 8'd255);

    pkt_out_ready = 1'b0;
    send(2'b01, 4'd3, 8'd5);
    check("pre_rst_data", pkt_out_data, {2'b01, 4'd5, 4'd3, 8'd105});
    rst_n = 1'b0;
    tick();
    check("rst_drop_valid", pkt_out_valid, 1'b0);
    check("rst_err_clear", err_cnt, 8'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("rst_back_load", pkt_in_ready, 1'b0);
    check("rst_load_ready_again", load_ready, 1'b1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_mem_server.md
Name: noc_mem_server

Overview:
- Clocked, parametrised memory node for the NoC CNN accelerator.
- Holds filter weights and ifmap pixels, serves PE read-request packets with response packets, and collects final result packets into a result buffer.
- Raises `done` after a configurable number of results; results are read back over a side port.
- Generalises the CSP memory node: sized filter, ifmap and result regions, valid/ready handshakes, range checking, restart, and optional accumulation.

Parameters:
- NODE_W, 4, node index field width
- DATA_W, 8, payload and memory word width
- ADDR_W, 8, local address width for all regions
- FILTER_NUM, 5, filter side; filter region holds FILTER_NUM*FILTER_NUM words
- IFMAP_NUM, 7, ifmap side; ifmap region holds IFMAP_NUM*IFMAP_NUM words
- DEPTH_R, 3, result rows
- WIDTH_R, 3, result columns; RESULT_NUM = DEPTH_R*WIDTH_R
- ACC_PASSES, 1, accumulation passes per result (used only with RESULT_ACCUM_EN)
- PKT_W, 2+2*NODE_W+DATA_W, packet width (18 at defaults)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- node_index  in  NODE_W  this node's NoC index
- start  in  1  one-cycle pulse; restarts result collection
- load_valid / load_ready  in / out  1 / 1  preload handshake
- load_sel  in  1  0=filter region, 1=ifmap region
- load_addr  in  ADDR_W  preload word address
- load_data  in  DATA_W  preload word
- pkt_in_valid / pkt_in_ready  in / out  1 / 1  NoC ingress handshake
- pkt_in_data  in  PKT_W  ingress packet
- pkt_out_valid / pkt_out_ready  out / in  1 / 1  NoC egress handshake
- pkt_out_data  out  PKT_W  egress packet
- rd_req_valid  in  1  result readback request
- rd_req_addr  in  ADDR_W  result index
- rd_resp_valid  out  1  readback data valid
- rd_resp_data  out  DATA_W  readback data
- done  out  1  all results collected (level)
- err_cnt  out  8  saturating count of bad packets and addresses

Behaviour:
- Clocking: single clock domain; all state updates on the rising edge of clk.
- Reset: synchronous, active-low on rst_n. When low, outputs clear to: pkt_out_valid=0, pkt_out_data=0, rd_resp_valid=0, rd_resp_data=0, done=0, err_cnt=0, load_ready=0, pkt_in_ready=0. Internally: state=LOAD, filter_loaded=0, ifmap_loaded=0, res_ptr=0, pass_cnt=0, result memory zeroed. Filter and ifmap contents are not reset. Reset mid-transfer drops any held egress packet.
- Packet fields: [PKT_W-1:PKT_W-2] type, then src node (NODE_W), dst node (NODE_W), payload [DATA_W-1:0].
- Packet types: 01 = ifmap read (payload = address), 10 = filter read, 00 = result write (payload = value), 11 = illegal.
- Preload: load_ready=1 whenever out of reset. A word is written on a cycle where load_valid && load_ready. Writing the last word of a region (FILTER_NUM^2-1 or IFMAP_NUM^2-1) sets that region's loaded flag. A load_addr outside the region is dropped and increments err_cnt.
- State machine:
  - LOAD: go to SERVE when both loaded flags are set.
  - SERVE: go to DONE when the final result write is accepted.
  - DONE: go to SERVE on start. start during SERVE clears res_ptr and pass_cnt and zeroes the result memory. start during LOAD is ignored.
- Ingress ready: pkt_in_ready = (state==SERVE) && (!pkt_out_valid || pkt_out_ready).
- Read requests: accepted at cycle t; pkt_out_valid=1 at t+1.
  - Response fields: type = request type, src = node_index, dst = request src, payload = region word.
  - Response is held stable until pkt_out_ready.
  - Address out of range: payload 0, err_cnt++.
  - Read and preload to the same address in the same cycle: the response carries the old word.
- Result writes: result_mem[res_ptr] = payload; res_ptr++. No egress packet is produced. When res_ptr reaches RESULT_NUM: done=1 in the next cycle, state=DONE, pkt_in_ready=0.
- Illegal type 11: consumed, err_cnt++, no response.
- err_cnt: saturates at 255.
- Readback: accepted any cycle out of reset. rd_resp_valid and rd_resp_data are valid exactly one cycle later. Index >= RESULT_NUM returns 0 and does not count as an error.

Optional Feature:
- Macro: RESULT_ACCUM_EN.
- Defined: a result write sets result_mem[res_ptr] = result_mem[res_ptr] + payload, saturating at 2^DATA_W-1. res_ptr wraps to 0 at RESULT_NUM and pass_cnt increments. done asserts once pass_cnt reaches ACC_PASSES.
- Undefined: result writes overwrite, and ACC_PASSES is ignored.

Test Plan:
- Preload filter with word i=i and ifmap with word i=100+i; check state stays LOAD until both last words are written, then pkt_in_ready rises.
- In SERVE, send ifmap read {01,src=3,dst=0,addr=10} → next cycle egress {01,src=node_index,dst=3,payload=110}; hold pkt_out_ready=0 for 3 cycles → data stable, pkt_in_ready=0.
- Send 9 result writes with values 1..9 → done=1 the cycle after the 9th write; readback of index 4 returns 5; index 20 returns 0.
- Send filter read addr=30 and one type-11 packet → payload 0 returned for the read, no response for type 11, err_cnt=2.
- Assert start in DONE → done=0, result memory reads 0; drive rst_n=0 mid-response → pkt_out_valid=0 the next cycle and state=LOAD.
- With RESULT_ACCUM_EN and ACC_PASSES=2, write 18 results of value 200 → each result saturates at 255; done only after the 18th write.
